plru_victim_sel: RTL

PLRU_VICTIM_SEL -- requirements
Module: plru_victim_sel

---
 rtl/cache_define_pkg.sv | 35 +++
 rtl/plru_victim_sel.sv | 129 ++++++++++++
 2 files changed

// File: rtl/cache_define_pkg.sv
// rtl/cache_define_pkg.sv - shared cache constants, PLRU victim-select state enum and tree-walk step function
package cache_define;

  // Default associativity and the constants derived from it
  localparam int DEF_WAYS      = 8;
  localparam int DEF_LOG2W     = $clog2(DEF_WAYS);
  localparam int DEF_PLRU_BITS = DEF_WAYS - 1;

  // Widest tree the step function handles: 32 ways, node indices up to 62
  localparam int MAX_WAYS   = 32;
  localparam int MAX_IDX_W  = 6;
  localparam int PLRU_PAD_W = 2 ** MAX_IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } plru_vs_state_e;

  typedef struct packed {
    logic                 way_bit;
    logic [MAX_IDX_W-1:0] next_index;
  } plru_step_t;

  // One tree level: the victim follows the side the node does not point at,
  // so the way bit is the inverse of the stored node bit.
  function automatic plru_step_t plru_step(input logic [PLRU_PAD_W-1:0] plru,
                                           input logic [MAX_IDX_W-1:0]  index);
    plru_step_t s;
    s.way_bit    = ~plru[index];
    s.next_index = (index << 1) + MAX_IDX_W'(s.way_bit ? 2 : 1);
    return s;
  endfunction

endpackage

// File: rtl/plru_victim_sel.sv
// rtl/plru_victim_sel.sv - tree-PLRU victim way selector, one level per cycle; option PLRU_INVALID_FIRST_EN
module plru_victim_sel
  import cache_define::*;
#(
  parameter int WAYS = DEF_WAYS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  output logic                     req_rdy,
  input  logic [WAYS-2:0]          plru_in,
  input  logic [WAYS-1:0]          valid_mask,
  output logic                     victim_vld,
  output logic [$clog2(WAYS)-1:0]  victim_way,
  output logic                     victim_inv,
  input  logic                     victim_ack
);

  localparam int LOG2W     = $clog2(WAYS);
  localparam int PLRU_BITS = WAYS - 1;
  localparam int LVL_W     = (LOG2W > 1) ? $clog2(LOG2W) : 1;
  localparam logic [LVL_W-1:0] LAST_LVL = LVL_W'(LOG2W - 1);

  plru_vs_state_e state, state_nxt;

  logic [PLRU_BITS-1:0]  snap;
  logic [MAX_IDX_W-1:0]  index;
  logic [LVL_W-1:0]      level;
  logic [PLRU_PAD_W-1:0] plru_pad;
  plru_step_t            step;
  logic                  accept;
  logic                  take_invalid;

  assign accept   = req && (state == IDLE);
  assign plru_pad = PLRU_PAD_W'(snap);
  assign step     = plru_step(plru_pad, index);

  assign req_rdy    = (state == IDLE);
  assign victim_vld = (state == DONE);

`ifdef PLRU_INVALID_FIRST_EN
  logic [LOG2W-1:0] inv_way;
  logic             inv_r;

  assign take_invalid = ~&valid_mask;
  assign victim_inv   = inv_r;

  // Lowest-index invalid way wins
  always_comb begin
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_mask[i]) inv_way = LOG2W'(i);
    end
  end

  // Invalid flag is set only on an invalid-first accept and cleared on the way back to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_r <= 1'b0;
    end else if (accept) begin
      inv_r <= take_invalid;
    end else if (state == DONE && victim_ack) begin
      inv_r <= 1'b0;
    end
  end
`else
  logic unused_valid_mask;

  assign unused_valid_mask = ^valid_mask;
  assign take_invalid      = 1'b0;
  assign victim_inv        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: accept from IDLE, walk LOG2W levels, hold result until acknowledged
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) state_nxt = take_invalid ? DONE : WALK;
      end
      WALK: begin
        if (level == LAST_LVL) state_nxt = DONE;
      end
      DONE: begin
        if (victim_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: snapshot on accept, then shift one resolved way bit in per WALK cycle (MSB first)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap       <= '0;
      index      <= '0;
      level      <= '0;
      victim_way <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            snap  <= plru_in;
            index <= '0;
            level <= '0;
`ifdef PLRU_INVALID_FIRST_EN
            victim_way <= take_invalid ? inv_way : '0;
`else
            victim_way <= '0;
`endif
          end
        end
        WALK: begin
          victim_way <= LOG2W'({victim_way, step.way_bit});
          index      <= step.next_index;
          level      <= level + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
